// File: rtl/game_timer.sv
// Scoreboard countdown clock: MM:SS packed BCD, ticked by rising edges of the
// divider's slow clock sclk, with start/stop/load control and an expiry horn.
module game_timer #(
  parameter logic [7:0] DEFAULT_MIN = 8'h10,
  parameter logic [7:0] DEFAULT_SEC = 8'h00,
  parameter int         HORN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       horn
);

  localparam int HW = $clog2(HORN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state, state_nx;
  logic          sclk_d, tick, expire_nx;
  logic [7:0]    min_nx, sec_nx;
  logic [HW-1:0] hcnt;

  assign tick = sclk & ~sclk_d;

  // A tens digit past its limit means the value is beyond the field maximum,
  // so the whole field saturates (A7 -> 99, 7C -> 59); otherwise only the
  // ones digit is clamped to 9.
  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [3:0] tmax);
    if (v[7:4] > tmax) clamp = {tmax, 4'd9};
    else               clamp = {v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
  endfunction

  function automatic logic [15:0] dec(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    dec = {m1, m0, s1, s0};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    min_nx    = min_bcd;
    sec_nx    = sec_bcd;
    expire_nx = 1'b0;
    if (load) begin
      state_nx = IDLE;
      min_nx   = clamp(preset_min, 4'd9);
      sec_nx   = clamp(preset_sec, 4'd5);
    end else begin
      case (state)
        IDLE:    if (!stop && start && {min_bcd, sec_bcd} != 16'h0000) state_nx = RUN;
        RUN: begin
          if (stop) state_nx = PAUSE;
          else if (tick && {min_bcd, sec_bcd} != 16'h0000) begin
            {min_nx, sec_nx} = dec({min_bcd, sec_bcd});
            if ({min_bcd, sec_bcd} == 16'h0001) begin
              state_nx  = EXPIRED;
              expire_nx = 1'b1;
            end
          end
        end
        PAUSE:   if (!stop && start) state_nx = RUN;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_d  <= 1'b0;
      min_bcd <= DEFAULT_MIN;
      sec_bcd <= DEFAULT_SEC;
      running <= 1'b0;
      expired <= 1'b0;
      horn    <= 1'b0;
      hcnt    <= '0;
    end else begin
      sclk_d  <= sclk;
      min_bcd <= min_nx;
      sec_bcd <= sec_nx;
      running <= (state_nx == RUN);
      expired <= (state_nx == EXPIRED);
      // hcnt holds the remaining high cycles after the current one
      if (load) begin
        horn <= 1'b0;
        hcnt <= '0;
      end else if (expire_nx) begin
        horn <= 1'b1;
        hcnt <= HW'(HORN_CYCLES - 1);
      end else if (horn) begin
        if (hcnt == '0) horn <= 1'b0;
        else            hcnt <= hcnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// Randomised + directed bench for game_timer; a seconds-based reference model
// feeds a scoreboard queue that a negedge monitor drains and compares.
module tb_game_timer;

  localparam int HORN = 16;

  logic       clk, reset, sclk, start, stop, load;
  logic [7:0] preset_min, preset_sec, min_bcd, sec_bcd;
  logic       running, expired, horn;

  game_timer #(.DEFAULT_MIN(8'h10), .DEFAULT_SEC(8'h00), .HORN_CYCLES(HORN)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .start(start), .stop(stop), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .running(running), .expired(expired), .horn(horn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] s;
    logic       run;
    logic       exp;
    logic       hrn;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // model: time as whole seconds; state 0 idle, 1 run, 2 pause, 3 expired
  int mt, mst, mleft;
  bit msp;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int clampv(input logic [7:0] v, input int tmax);
    int t, o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > tmax) return tmax * 10 + 9;
    return t * 10 + ((o > 9) ? 9 : o);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.m   = to_bcd(mt / 60);
    e.s   = to_bcd(mt % 60);
    e.run = (mst == 1);
    e.exp = (mst == 3);
    e.hrn = (mleft > 0);
    return e;
  endfunction

  task automatic model_reset();
    mt = 600; mst = 0; mleft = 0; msp = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit st, input bit sp, input bit ld,
                            input logic [7:0] pm, input logic [7:0] ps);
    bit tk;
    tk  = s && !msp;
    msp = s;
    if (ld) mleft = 0;
    else if (mleft > 0) mleft--;
    if (ld) begin
      mst = 0;
      mt  = clampv(pm, 9) * 60 + clampv(ps, 5);
    end else begin
      case (mst)
        0: if (!sp && st && mt != 0) mst = 1;
        1: if (sp) mst = 2;
           else if (tk && mt > 0) begin
             mt--;
             if (mt == 0) begin mst = 3; mleft = HORN; end
           end
        2: if (!sp && st) mst = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit s, input bit st = 0, input bit sp = 0, input bit ld = 0,
                      input logic [7:0] pm = 8'h00, input logic [7:0] ps = 8'h00);
    sclk = s; start = st; stop = sp; load = ld; preset_min = pm; preset_sec = ps;
    model_edge(s, st, sp, ld, pm, ps);
    q.push_back(model_out());
    @(posedge clk); #1;
  endtask

  task automatic pulse();
    step(1); step(0); step(0);
  endtask

  task automatic expect_now(input string nm, input logic [7:0] m, input logic [7:0] s,
                            input bit r, input bit e, input bit h);
    checks++;
    if (min_bcd !== m || sec_bcd !== s || running !== r || expired !== e || horn !== h) begin
      errors++;
      $display("FAIL %s: got %h:%h run=%b exp=%b horn=%b, want %h:%h run=%b exp=%b horn=%b",
               nm, min_bcd, sec_bcd, running, expired, horn, m, s, r, e, h);
    end
  endtask

  // scoreboard monitor: one expected entry per active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (min_bcd !== e.m || sec_bcd !== e.s || running !== e.run ||
          expired !== e.exp || horn !== e.hrn) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got %h:%h run=%b exp=%b horn=%b, want %h:%h run=%b exp=%b horn=%b",
                 $time, min_bcd, sec_bcd, running, expired, horn, e.m, e.s, e.run, e.exp, e.hrn);
      end
      checks++;
      if (min_bcd[7:4] > 4'd9 || min_bcd[3:0] > 4'd9 || sec_bcd[7:4] > 4'd5 || sec_bcd[3:0] > 4'd9) begin
        errors++;
        $display("FAIL digits t=%0t: got %h:%h", $time, min_bcd, sec_bcd);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    model_reset();
    #1;
    expect_now("async_reset", 8'h10, 8'h00, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; sclk = 0; start = 0; stop = 0; load = 0; preset_min = 0; preset_sec = 0;
    model_reset();
    repeat (2) @(negedge clk);
    expect_now("reset_state", 8'h10, 8'h00, 0, 0, 0);
    #1 reset = 1'b1;

    // 1: ticks without start do nothing
    repeat (3) pulse();
    expect_now("idle_no_dec", 8'h10, 8'h00, 0, 0, 0);

    // 2: 00:03 down to expiry, horn, hold at 00:00
    step(0, 0, 0, 1, 8'h00, 8'h03);
    step(0, 1);
    pulse(); pulse();
    expect_now("t2_0001", 8'h00, 8'h01, 1, 0, 0);
    step(1);
    expect_now("t2_expire", 8'h00, 8'h00, 0, 1, 1);
    repeat (24) step(0);
    expect_now("t2_horn_off", 8'h00, 8'h00, 0, 1, 0);
    repeat (3) pulse();
    step(0, 1, 1);
    expect_now("t2_hold", 8'h00, 8'h00, 0, 1, 0);

    // 3: borrow across all digits
    step(0, 0, 0, 1, 8'h10, 8'h00);
    step(0, 1);
    pulse();
    expect_now("t3_0959", 8'h09, 8'h59, 1, 0, 0);
    step(0, 0, 0, 1, 8'h01, 8'h00);
    step(0, 1);
    pulse();
    expect_now("t3_0059", 8'h00, 8'h59, 1, 0, 0);

    // 4: stop coincident with tick, pause ignores ticks
    step(0, 0, 0, 1, 8'h05, 8'h30);
    step(0, 1);
    step(1, 0, 1);
    step(0);
    repeat (3) pulse();
    expect_now("t4_pause", 8'h05, 8'h30, 0, 0, 0);
    step(0, 1);
    pulse();
    expect_now("t4_resume", 8'h05, 8'h29, 1, 0, 0);

    // 5: start at 00:00, clamps, load+start
    step(0, 0, 0, 1, 8'h00, 8'h00);
    step(0, 1);
    expect_now("t5_zero_start", 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 8'hA7, 8'h7C);
    expect_now("t5_clamp", 8'h99, 8'h59, 0, 0, 0);
    step(0, 0, 0, 1, 8'h1A, 8'h5C);
    expect_now("t5_clamp_ones", 8'h19, 8'h59, 0, 0, 0);
    step(0, 1, 0, 1, 8'h02, 8'h00);
    expect_now("t5_load_start", 8'h02, 8'h00, 0, 0, 0);

    // 6: async reset mid-run
    step(0, 0, 0, 1, 8'h03, 8'h17);
    step(0, 1);
    step(1);
    do_reset();
    step(1);
    step(0);
    expect_now("t6_after_reset", 8'h10, 8'h00, 0, 0, 0);

    // random stress against the model
    for (int i = 0; i < 4000; i++) begin
      bit s, st, sp, ld;
      int r;
      logic [7:0] pm, ps;
      s  = ($urandom_range(0, 2) == 0) ? ~sclk : sclk;
      r  = $urandom_range(0, 99);
      ld = (r < 2);
      st = (r >= 2 && r < 10);
      sp = (r >= 10 && r < 12);
      pm = {4'd0, 4'($urandom_range(0, 1))};
      ps = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      step(s, st, sp, ld, pm, ps);
    end
    step(0);
    @(negedge clk); @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
